// File: rtl/led_pattern_gen.sv
// LED pattern generator: a programmable prescaler produces a step tick that advances
// an N_LED-wide pattern (binary up/down, rotate-left, bounce); manual step and pause supported.
module led_pattern_gen #(
  parameter int N_LED    = 4,
  parameter int TICK_DIV = 100000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             step,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam int CW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_ROT    = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    per_m1;
  logic [31:0]      shifted;
  logic [1:0]       mode_q;
  dir_t             dir;
  dir_t             dir_nxt;
  logic             tick_evt;
  logic             adv;
  logic [N_LED-1:0] nxt;
  logic [N_LED-1:0] start;

  // Period is clamped to at least one cycle, so per_m1 never underflows.
  always_comb begin
    shifted  = 32'(TICK_DIV) >> speed;
    per_m1   = (shifted > 32'd1) ? CW'(shifted - 32'd1) : '0;
    tick_evt = enable && (cnt >= per_m1);
    adv      = tick_evt || step;
  end

  always_comb begin
    nxt     = led;
    dir_nxt = dir;
    start   = '0;
    case (mode_t'(mode))
      MODE_UP:     start = '0;
      MODE_DOWN:   start = {N_LED{1'b1}};
      MODE_ROT:    start = N_LED'(1);
      MODE_BOUNCE: start = N_LED'(1);
      default:     start = '0;
    endcase
    case (mode_t'(mode_q))
      MODE_UP:   nxt = led + N_LED'(1);
      MODE_DOWN: nxt = led - N_LED'(1);
      // Shift-and-or form degenerates to a hold when N_LED is 1.
      MODE_ROT:  nxt = (led << 1) | (led >> (N_LED - 1));
      MODE_BOUNCE: begin
        if (N_LED == 1) begin
          nxt = led;
        end else if (dir == DIR_LEFT) begin
          nxt = led << 1;
          if (nxt[N_LED-1]) dir_nxt = DIR_RIGHT;
        end else begin
          nxt = led >> 1;
          if (nxt[0]) dir_nxt = DIR_LEFT;
        end
      end
      default: nxt = led;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      led    <= '0;
      mode_q <= 2'd0;
      dir    <= DIR_LEFT;
      tick   <= 1'b0;
    end else begin
      mode_q <= mode;
      if (enable) begin
        cnt <= tick_evt ? '0 : cnt + CW'(1);
      end
      // A mode change reloads the start value and swallows any advance that cycle.
      if (mode != mode_q) begin
        led  <= start;
        dir  <= DIR_LEFT;
        tick <= 1'b0;
      end else if (adv) begin
        led  <= nxt;
        dir  <= dir_nxt;
        tick <= 1'b1;
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: N_LED=4/TICK_DIV=4 main instance plus an N_LED=1 instance.
module tb_led_pattern_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [1:0] speed = 2'd0;
  logic       step = 1'b0;
  logic [3:0] led;
  logic       tick;
  logic [1:0] mode1 = 2'd0;
  logic [0:0] led1;
  logic       tick1;

  int errors = 0;
  int checks = 0;
  int n;
  logic [3:0] exp2 [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

  led_pattern_gen #(.N_LED(4), .TICK_DIV(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .speed(speed),
    .step(step), .led(led), .tick(tick)
  );

  led_pattern_gen #(.N_LED(1), .TICK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode1), .speed(speed),
    .step(step), .led(led1), .tick(tick1)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (tick !== 1'b1 && cnt < 50);
    chk({tag, "_seen"}, {31'd0, tick}, 32'd1);
  endtask

  initial begin
    // reset state
    cyc();
    cyc();
    chk("rst_led", led, 0);
    chk("rst_tick", tick, 0);
    reset = 1'b0;

    // binary up, period 4, wraps 15 -> 0
    for (int i = 1; i <= 16; i++) begin
      wait_tick("t1", n);
      chk("t1_period", n, 4);
      chk("t1_led", led, i % 16);
    end
    cyc();
    chk("t1_width", tick, 0);
    chk("t1_hold", led, 0);

    // bounce
    mode = 2'd3;
    cyc();
    chk("t2_load", led, 4'b0001);
    chk("t2_load_tick", tick, 0);
    for (int i = 0; i < 7; i++) begin
      wait_tick("t2", n);
      chk("t2_led", led, exp2[i]);
    end

    // pause and manual step
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t3_frozen_led", led, 4'b0010);
      chk("t3_frozen_tick", tick, 0);
    end
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("t3_step_led", led, 4'b0100);
    chk("t3_step_tick", tick, 1);
    cyc();
    chk("t3_step_once", led, 4'b0100);
    chk("t3_step_tick_low", tick, 0);
    enable = 1'b1;
    wait_tick("t3", n);
    chk("t3_cnt_kept", n, 4);
    chk("t3_led", led, 4'b1000);

    // step coincident with wrap advances once
    repeat (3) cyc();
    chk("t4_pre_tick", tick, 0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("t4_coinc_led", led, 4'b0100);
    chk("t4_coinc_tick", tick, 1);
    repeat (3) cyc();
    chk("t4_pre_speed", led, 4'b0100);
    speed = 2'd2;
    cyc();
    chk("t4_fast1_led", led, 4'b0010);
    chk("t4_fast1_tick", tick, 1);
    cyc();
    chk("t4_fast2_led", led, 4'b0001);
    chk("t4_fast2_tick", tick, 1);
    cyc();
    chk("t4_fast3_led", led, 4'b0010);
    speed = 2'd0;

    // mode change on a tick cycle: load wins
    mode = 2'd0;
    cyc();
    chk("t5_up_load", led, 0);
    cyc();
    cyc();
    chk("t5_pre_tick", tick, 0);
    mode = 2'd1;
    cyc();
    chk("t5_down_load", led, 4'b1111);
    chk("t5_load_tick", tick, 0);
    wait_tick("t5a", n);
    chk("t5a_period", n, 4);
    chk("t5a_led", led, 4'b1110);
    wait_tick("t5b", n);
    chk("t5b_period", n, 4);
    chk("t5b_led", led, 4'b1101);

    // reset mid-bounce
    mode = 2'd3;
    speed = 2'd2;
    cyc();
    chk("t6_load", led, 4'b0001);
    repeat (4) cyc();
    chk("t6_mid", led, 4'b0100);
    reset = 1'b1;
    cyc();
    chk("t6_rst_led", led, 0);
    chk("t6_rst_tick", tick, 0);
    mode = 2'd0;
    speed = 2'd0;
    cyc();
    chk("t6_rst_hold", led, 0);
    reset = 1'b0;
    wait_tick("t6", n);
    chk("t6_cnt_cleared", n, 4);
    chk("t6_led", led, 1);

    // single-LED instance: bounce and rotate hold 1
    mode1 = 2'd3;
    cyc();
    chk("n1_bounce_load", led1, 1);
    chk("n1_bounce_load_tick", tick1, 0);
    cyc();
    chk("n1_bounce_led", led1, 1);
    chk("n1_bounce_tick", tick1, 1);
    cyc();
    chk("n1_bounce_led2", led1, 1);
    mode1 = 2'd2;
    cyc();
    chk("n1_rot_load", led1, 1);
    chk("n1_rot_load_tick", tick1, 0);
    cyc();
    chk("n1_rot_led", led1, 1);
    chk("n1_rot_tick", tick1, 1);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
